// File: rtl/conv_pixel_streamer_if.sv
// Load/control/stream bundle between the pixel streamer and its user.
// slave = streamer side, master = loader/engine side.
interface conv_pixel_streamer_if #(
   parameter int unsigned DATA_W = 16
);
   logic              ld_valid;
   logic [DATA_W-1:0] ld_data;
   logic              ld_ready;
   logic              ld_clear;
   logic              start;
   logic              hold;
   logic [DATA_W-1:0] data_in;
   logic              rdata_r;
   logic              busy;
   logic              done;

   modport master (
      output ld_valid, ld_data, ld_clear, start, hold,
      input  ld_ready, data_in, rdata_r, busy, done
   );

   modport slave (
      input  ld_valid, ld_data, ld_clear, start, hold,
      output ld_ready, data_in, rdata_r, busy, done
   );
endinterface

// File: rtl/conv_pixel_streamer.sv
// Buffers one image and streams it row-major to the conv1 engine.
// Define CONV_STREAMER_FLUSH_EN to append one zero-valued flush beat after the last pixel.
module conv_pixel_streamer #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned IMG_W  = 28,
   parameter int unsigned IMG_H  = 28
) (
   input  logic                   clk,
   input  logic                   rst,
   conv_pixel_streamer_if.slave   bus
);
   localparam int unsigned N = IMG_W * IMG_H;
`ifdef CONV_STREAMER_FLUSH_EN
   localparam int unsigned NumBeats = N + 1;
`else
   localparam int unsigned NumBeats = N;
`endif
   localparam int unsigned CntW  = $clog2(NumBeats + 1);
   localparam int unsigned AddrW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {StIdle, StLoad, StReady, StStream} state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   ld_cnt_q, ld_cnt_d;
   logic [CntW-1:0]   idx_q, idx_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              rdata_q, rdata_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              ld_ready_q, ld_ready_d;
   logic              we;
   logic [AddrW-1:0]  wr_addr, rd_addr;
   logic [DATA_W-1:0] rd_q;
   logic [DATA_W-1:0] mem [N];

   assign wr_addr = AddrW'(ld_cnt_q);
   // Read ahead at the next index so rd_q already holds the pixel the next beat needs.
   assign rd_addr = (idx_d < CntW'(N)) ? AddrW'(idx_d) : '0;

   always_comb begin
      state_d  = state_q;
      ld_cnt_d = ld_cnt_q;
      idx_d    = idx_q;
      data_d   = data_q;
      rdata_d  = 1'b0;
      busy_d   = busy_q;
      done_d   = 1'b0;
      we       = 1'b0;
      unique case (state_q)
         StIdle, StLoad: begin
            if (bus.ld_clear) begin
               state_d  = StIdle;
               ld_cnt_d = '0;
            end else if (bus.ld_valid && ld_ready_q) begin
               we = 1'b1;
               if (ld_cnt_q == CntW'(N - 1)) begin
                  state_d  = StReady;
                  ld_cnt_d = '0;
               end else begin
                  state_d  = StLoad;
                  ld_cnt_d = ld_cnt_q + 1'b1;
               end
            end
         end
         StReady: begin
            if (bus.ld_clear) begin
               state_d  = StIdle;
               ld_cnt_d = '0;
            end else if (bus.start && !bus.hold) begin
               state_d = StStream;
               idx_d   = '0;
            end
         end
         StStream: begin
            busy_d = 1'b1;
            if (!bus.hold) begin
               if (idx_q == CntW'(NumBeats)) begin
                  state_d = StReady;
                  idx_d   = '0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  data_d  = (idx_q < CntW'(N)) ? rd_q : '0;
                  rdata_d = 1'b1;
                  idx_d   = idx_q + 1'b1;
               end
            end
         end
      endcase
      ld_ready_d = (state_d == StIdle) || (state_d == StLoad);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         ld_cnt_q   <= '0;
         idx_q      <= '0;
         data_q     <= '0;
         rdata_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         ld_ready_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ld_cnt_q   <= ld_cnt_d;
         idx_q      <= idx_d;
         data_q     <= data_d;
         rdata_q    <= rdata_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         ld_ready_q <= ld_ready_d;
      end
   end

   // Image storage survives reset; only control state is cleared.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[wr_addr] <= bus.ld_data;
      end
      rd_q <= mem[rd_addr];
   end

   assign bus.ld_ready = ld_ready_q;
   assign bus.data_in  = data_q;
   assign bus.rdata_r  = rdata_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
endmodule

// File: tb/tb_conv_pixel_streamer.sv
// Scoreboard bench for conv_pixel_streamer: expected beats/done queued by stimulus,
// consumed by a negedge monitor.
module tb_conv_pixel_streamer;
   localparam int DATA_W = 16;
   localparam int IMG_W  = 28;
   localparam int IMG_H  = 28;
   localparam int N      = IMG_W * IMG_H;
`ifdef CONV_STREAMER_FLUSH_EN
   localparam int FL = 1;
`else
   localparam int FL = 0;
`endif
   localparam int DoneTok = -1;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   conv_pixel_streamer_if #(.DATA_W(DATA_W)) bus ();

   conv_pixel_streamer #(
      .DATA_W (DATA_W),
      .IMG_W  (IMG_W),
      .IMG_H  (IMG_H)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int t0     = 0;
   int exp_q[$];

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      #1;
   endtask

   // Monitor: every presented beat or done pulse must match the head of the queue.
   always @(negedge clk) begin
      int e;
      if (bus.rdata_r) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got data %0d, expected no beat", bus.data_in);
         end else begin
            e = exp_q.pop_front();
            check("beat_data", int'(bus.data_in), e);
         end
      end
      if (bus.done) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1, expected no done");
         end else begin
            e = exp_q.pop_front();
            check("done_order", e, DoneTok);
         end
      end
      if (bus.rdata_r && bus.done) check("beat_and_done_overlap", 1, 0);
   end

   task automatic push_image();
      for (int i = 0; i < N; i++) exp_q.push_back(i + 1);
      if (FL == 1) exp_q.push_back(0);
      exp_q.push_back(DoneTok);
   endtask

   task automatic load_range(input int lo, input int hi);
      bus.ld_valid = 1'b1;
      for (int i = lo; i <= hi; i++) begin
         int w;
         w = 0;
         bus.ld_data = 16'(i + 1);
         while (!bus.ld_ready && w < 20) begin
            tick();
            w++;
         end
         if (w >= 20) check("ld_ready_timeout", 0, 1);
         tick();
      end
      bus.ld_valid = 1'b0;
   endtask

   task automatic start_stream();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      t0 = cyc;
   endtask

   task automatic wait_done(input string name, input int req_cycles);
      int w;
      w = 0;
      while (!bus.done && w < N + 200) begin
         tick();
         w++;
      end
      check(name, cyc - t0, req_cycles);
      tick();
      check("done_one_cycle", int'(bus.done), 0);
      check("busy_after_done", int'(bus.busy), 0);
   endtask

   task automatic wait_beat(input int val);
      int w;
      w = 0;
      while (!(bus.rdata_r && int'(bus.data_in) == val) && w < N + 200) begin
         tick();
         w++;
      end
      check("beat_reached", int'(bus.data_in), val);
   endtask

   task automatic stream_clean(input string name);
      push_image();
      start_stream();
      tick();
      check("first_beat_rdata", int'(bus.rdata_r), 1);
      check("first_beat_busy", int'(bus.busy), 1);
      wait_done(name, N + 1 + FL);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      bus.ld_valid = 1'b0;
      bus.ld_data  = '0;
      bus.ld_clear = 1'b0;
      bus.start    = 1'b0;
      bus.hold     = 1'b0;
      tick();
      tick();
      check("rst_ld_ready", int'(bus.ld_ready), 0);
      check("rst_data_in", int'(bus.data_in), 0);
      check("rst_rdata_r", int'(bus.rdata_r), 0);
      check("rst_busy", int'(bus.busy), 0);
      check("rst_done", int'(bus.done), 0);
      rst = 1'b0;
      tick();
      check("idle_ld_ready", int'(bus.ld_ready), 1);

      // Partial load, then a start that must be ignored.
      load_range(0, 9);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("start_in_load_busy", int'(bus.busy), 0);
      end
      check("start_in_load_ld_ready", int'(bus.ld_ready), 1);
      load_range(10, N - 1);
      check("full_ld_ready", int'(bus.ld_ready), 0);
      check("full_rdata_r", int'(bus.rdata_r), 0);

      // Stream with junk offered on the load port throughout.
      push_image();
      start_stream();
      bus.ld_valid = 1'b1;
      bus.ld_data  = 16'hbeef;
      tick();
      check("first_beat_rdata", int'(bus.rdata_r), 1);
      check("first_beat_data", int'(bus.data_in), 1);
      check("stream_ld_ready", int'(bus.ld_ready), 0);
      wait_done("done_latency_nostall", N + 1 + FL);
      bus.ld_valid = 1'b0;

      // Restream without reload proves the buffer was untouched.
      stream_clean("done_latency_restream");

      // Three-cycle stall starting when value 101 is presented.
      push_image();
      start_stream();
      wait_beat(101);
      bus.hold = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("stall_rdata_r", int'(bus.rdata_r), 0);
         check("stall_data_in", int'(bus.data_in), 101);
      end
      bus.hold = 1'b0;
      tick();
      check("after_stall_data", int'(bus.data_in), 102);
      check("after_stall_rdata", int'(bus.rdata_r), 1);
      wait_done("done_latency_stall", N + 1 + FL + 3);

      // Clear beats start in READY.
      bus.start    = 1'b1;
      bus.ld_clear = 1'b1;
      tick();
      bus.start    = 1'b0;
      bus.ld_clear = 1'b0;
      check("clear_ld_ready", int'(bus.ld_ready), 1);
      for (int k = 0; k < 3; k++) begin
         tick();
         check("clear_busy", int'(bus.busy), 0);
      end

      // Reload, then reset partway through a stream.
      load_range(0, N - 1);
      for (int i = 0; i < 400; i++) exp_q.push_back(i + 1);
      start_stream();
      wait_beat(400);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_data_in", int'(bus.data_in), 0);
      check("midrst_rdata_r", int'(bus.rdata_r), 0);
      check("midrst_busy", int'(bus.busy), 0);
      check("midrst_done", int'(bus.done), 0);
      check("midrst_ld_ready", int'(bus.ld_ready), 0);
      for (int k = 0; k < 5; k++) tick();
      check("midrst_idle_ld_ready", int'(bus.ld_ready), 1);
      check("midrst_queue_drained", exp_q.size(), 0);

      load_range(0, N - 1);
      stream_clean("done_latency_after_reset");

      tick();
      tick();
      check("final_queue_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
